// File: rtl/move_executor_pkg.sv
// Shared moving-command encodings and FSM state codes for the motion blocks
// (move_executor and the semiauto mode controller).
package move_executor_pkg;

  localparam logic [3:0] MV_STOP       = 4'b0000;
  localparam logic [3:0] MV_FORWARD    = 4'b0001;
  localparam logic [3:0] MV_BACKWARD   = 4'b0010;
  localparam logic [3:0] MV_TURN_LEFT  = 4'b0100;
  localparam logic [3:0] MV_TURN_RIGHT = 4'b1000;

  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TURN = 2'd2,
    ST_COOL = 2'd3
  } state_t;

endpackage

// File: rtl/move_executor_ms_timer.sv
// Millisecond prescaler plus 11-bit down-counter; expires when both reach 0
// while running. A load restarts a full interval of (load value + 1) ms.
import move_executor_pkg::*;

module ms_timer #(
  parameter int CLK_PER_MS = 100000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_run,
  output logic             o_expire
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(CLK_PER_MS - 1);

  logic [PW-1:0]    r_presc;
  logic [CNT_W-1:0] r_count;

  assign o_expire = i_run && (r_presc == '0) && (r_count == '0);

  // At expiry both stay parked at zero until the next load or clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_presc <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_presc <= PRESC_TOP;
      r_count <= i_load_val;
    end else if (i_run) begin
      if (r_presc != '0) begin
        r_presc <= r_presc - PW'(1);
      end else if (r_count != '0) begin
        r_presc <= PRESC_TOP;
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/move_executor.sv
// Applies moving commands to the motors; turns run for a fixed time followed
// by a cooldown, with one shared ms_timer timing both phases.
import move_executor_pkg::*;

module move_executor #(
  parameter int CLK_PER_MS = 100000,
  parameter int TURN_MS    = 900,
  parameter int COOL_MS    = 500
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       power,
  input  logic       cmd_valid,
  input  logic [3:0] cmd,
  output logic       cmd_ready,
  output logic [3:0] moving_state,
  output logic       busy,
  output logic       done,
  output logic       cmd_err,
  output logic       move_forward_light,
  output logic       move_backward_light,
  output logic       turn_left_light,
  output logic       turn_right_light,
  output logic [1:0] dbg_state
);

  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_MS - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_MS - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_moving;
  logic [3:0]       w_next_moving;
  logic             r_done, r_err;
  logic             w_done_next, w_err_next;
  logic             r_lamp_fwd, r_lamp_bwd, r_lamp_left, r_lamp_right;
  logic             w_ready, w_accept;
  logic             w_tmr_clr, w_tmr_load, w_tmr_run, w_tmr_expire;
  logic [CNT_W-1:0] w_tmr_val;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; ready never depends on valid, and commands
  // offered while ready is low are dropped, not queued.
  assign w_ready   = rst && power && ((r_state == ST_IDLE) || (r_state == ST_RUN));
  assign w_accept  = cmd_valid && w_ready;
  assign w_tmr_run = (r_state == ST_TURN) || (r_state == ST_COOL);

  ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_timer (
    .i_clk      (sys_clk),
    .i_rst_n    (rst),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_run      (w_tmr_run),
    .o_expire   (w_tmr_expire)
  );

  always_comb begin
    w_next_state  = r_state;
    w_next_moving = r_moving;
    w_tmr_clr     = 1'b0;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    w_done_next   = 1'b0;
    w_err_next    = 1'b0;
    if (!power) begin
      // Power loss overrides everything, including a pending expiry.
      w_next_state  = ST_IDLE;
      w_next_moving = MV_STOP;
      w_tmr_clr     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (w_accept) begin
            case (cmd)
              MV_STOP: begin
                w_next_state  = ST_IDLE;
                w_next_moving = MV_STOP;
              end
              MV_FORWARD, MV_BACKWARD: begin
                w_next_state  = ST_RUN;
                w_next_moving = cmd;
              end
              MV_TURN_LEFT, MV_TURN_RIGHT: begin
                w_next_state  = ST_TURN;
                w_next_moving = cmd;
                w_tmr_load    = 1'b1;
                w_tmr_val     = TURN_LOAD;
              end
              default: begin
                w_next_state  = ST_IDLE;
                w_next_moving = MV_STOP;
                w_err_next    = 1'b1;
              end
            endcase
          end
        end
        ST_TURN: begin
          if (w_tmr_expire) begin
            w_next_state  = ST_COOL;
            w_next_moving = MV_STOP;
            w_tmr_load    = 1'b1;
            w_tmr_val     = COOL_LOAD;
          end
        end
        ST_COOL: begin
          if (w_tmr_expire) begin
            w_next_state = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
        default: begin
          w_next_state  = ST_IDLE;
          w_next_moving = MV_STOP;
        end
      endcase
    end
  end

  // Lamps decode the next moving state so they change on the same edge as it.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_moving     <= MV_STOP;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_lamp_fwd   <= 1'b0;
      r_lamp_bwd   <= 1'b0;
      r_lamp_left  <= 1'b0;
      r_lamp_right <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_moving     <= w_next_moving;
      r_done       <= w_done_next;
      r_err        <= w_err_next;
      r_lamp_fwd   <= (w_next_moving == MV_FORWARD);
      r_lamp_bwd   <= (w_next_moving == MV_BACKWARD);
      r_lamp_left  <= (w_next_moving == MV_TURN_LEFT);
      r_lamp_right <= (w_next_moving == MV_TURN_RIGHT);
    end
  end

  assign cmd_ready           = w_ready;
  assign moving_state        = r_moving;
  assign busy                = w_tmr_run;
  assign done                = r_done;
  assign cmd_err             = r_err;
  assign move_forward_light  = r_lamp_fwd;
  assign move_backward_light = r_lamp_bwd;
  assign turn_left_light     = r_lamp_left;
  assign turn_right_light    = r_lamp_right;
  assign dbg_state           = r_state;

endmodule

// File: tb/tb_move_executor.sv
// Directed bench for move_executor with CLK_PER_MS=4, TURN_MS=3, COOL_MS=2:
// a turn is 12 cycles, its cooldown 8 cycles.
import move_executor_pkg::*;

module tb_move_executor;

  logic       sys_clk;
  logic       rst;
  logic       power;
  logic       cmd_valid;
  logic [3:0] cmd;
  logic       cmd_ready;
  logic [3:0] moving_state;
  logic       busy;
  logic       done;
  logic       cmd_err;
  logic       move_forward_light;
  logic       move_backward_light;
  logic       turn_left_light;
  logic       turn_right_light;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  move_executor #(.CLK_PER_MS(4), .TURN_MS(3), .COOL_MS(2)) dut (
    .sys_clk             (sys_clk),
    .rst                 (rst),
    .power               (power),
    .cmd_valid           (cmd_valid),
    .cmd                 (cmd),
    .cmd_ready           (cmd_ready),
    .moving_state        (moving_state),
    .busy                (busy),
    .done                (done),
    .cmd_err             (cmd_err),
    .move_forward_light  (move_forward_light),
    .move_backward_light (move_backward_light),
    .turn_left_light     (turn_left_light),
    .turn_right_light    (turn_right_light),
    .dbg_state           (dbg_state)
  );

  // Clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge sys_clk);
  endtask

  function automatic logic [3:0] lamps();
    return {turn_right_light, turn_left_light, move_backward_light, move_forward_light};
  endfunction

  task automatic offer(input logic [3:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_forward();
    rst = 1'b0; power = 1'b1; cmd_valid = 1'b0; cmd = 4'b0000;
    repeat (2) step();
    n_cmp++;
    if ({dbg_state, moving_state, cmd_ready, busy, done, cmd_err, lamps()} !==
        {ST_IDLE, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}) begin
      n_err++;
      $display("FAIL reset_outputs: got st=%0d mv=%b rdy=%b busy=%b done=%b err=%b lamps=%b, want st=0 mv=0000 all 0",
               dbg_state, moving_state, cmd_ready, busy, done, cmd_err, lamps());
    end
    n_cmp++;
    if ({dut.u_timer.r_presc, dut.u_timer.r_count} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_timer: got presc=%0d count=%0d, want 0 0", dut.u_timer.r_presc, dut.u_timer.r_count);
    end
    rst = 1'b1;
    offer(MV_FORWARD);
    n_cmp++;
    if ({dbg_state, moving_state, lamps(), cmd_ready} !== {ST_RUN, 4'b0001, 4'b0001, 1'b1}) begin
      n_err++;
      $display("FAIL forward_after_reset: got st=%0d mv=%b lamps=%b rdy=%b, want st=1 mv=0001 lamps=0001 rdy=1",
               dbg_state, moving_state, lamps(), cmd_ready);
    end
  endtask

  task automatic test_turn_left();
    logic [1:0]  ep;
    logic [10:0] ec;
    offer(MV_TURN_LEFT);
    for (int i = 0; i < 12; i++) begin
      ep = 2'(3 - (i % 4));
      ec = 11'(2 - (i / 4));
      n_cmp++;
      if ({dbg_state, moving_state, busy, cmd_ready, done, lamps()} !==
          {ST_TURN, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100}) begin
        n_err++;
        $display("FAIL turn_cycle%0d: got st=%0d mv=%b busy=%b rdy=%b done=%b lamps=%b, want st=2 mv=0100 busy=1 rdy=0 done=0 lamps=0100",
                 i + 1, dbg_state, moving_state, busy, cmd_ready, done, lamps());
      end
      n_cmp++;
      if ({dut.u_timer.r_presc, dut.u_timer.r_count} !== {ep, ec}) begin
        n_err++;
        $display("FAIL turn_timer%0d: got presc=%0d count=%0d, want %0d %0d",
                 i + 1, dut.u_timer.r_presc, dut.u_timer.r_count, ep, ec);
      end
      step();
    end
    for (int i = 0; i < 8; i++) begin
      ep = 2'(3 - (i % 4));
      ec = 11'(1 - (i / 4));
      n_cmp++;
      if ({dbg_state, moving_state, busy, cmd_ready, done, lamps(), dut.u_timer.r_presc, dut.u_timer.r_count} !==
          {ST_COOL, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, ep, ec}) begin
        n_err++;
        $display("FAIL cool_cycle%0d: got st=%0d mv=%b busy=%b rdy=%b done=%b lamps=%b presc=%0d count=%0d, want st=3 mv=0000 busy=1 rdy=0 done=0 lamps=0 presc=%0d count=%0d",
                 i + 1, dbg_state, moving_state, busy, cmd_ready, done, lamps(),
                 dut.u_timer.r_presc, dut.u_timer.r_count, ep, ec);
      end
      step();
    end
    n_cmp++;
    if ({dbg_state, moving_state, busy, cmd_ready, done} !== {ST_IDLE, 4'b0000, 1'b0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL turn_done: got st=%0d mv=%b busy=%b rdy=%b done=%b, want st=0 mv=0000 busy=0 rdy=1 done=1",
               dbg_state, moving_state, busy, cmd_ready, done);
    end
    step();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_one_cycle: got done=%b, want 0", done);
    end
  endtask

  task automatic test_ignore_in_cool();
    offer(MV_TURN_LEFT);
    repeat (12) step();
    cmd = MV_TURN_RIGHT;
    cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({dbg_state, moving_state, cmd_ready, done} !== {ST_COOL, 4'b0000, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL cool_ignore%0d: got st=%0d mv=%b rdy=%b done=%b, want st=3 mv=0000 rdy=0 done=0",
                 i + 1, dbg_state, moving_state, cmd_ready, done);
      end
      step();
    end
    n_cmp++;
    if ({dbg_state, moving_state, cmd_ready, done} !== {ST_IDLE, 4'b0000, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL expiry_wins: got st=%0d mv=%b rdy=%b done=%b, want st=0 mv=0000 rdy=1 done=1",
               dbg_state, moving_state, cmd_ready, done);
    end
    step();
    cmd_valid = 1'b0;
    n_cmp++;
    if ({dbg_state, moving_state, lamps(), done} !== {ST_TURN, 4'b1000, 4'b1000, 1'b0}) begin
      n_err++;
      $display("FAIL right_accepted: got st=%0d mv=%b lamps=%b done=%b, want st=2 mv=1000 lamps=1000 done=0",
               dbg_state, moving_state, lamps(), done);
    end
    repeat (11) step();
    n_cmp++;
    if ({dbg_state, moving_state} !== {ST_TURN, 4'b1000}) begin
      n_err++;
      $display("FAIL right_turn_last: got st=%0d mv=%b, want st=2 mv=1000", dbg_state, moving_state);
    end
    step();
    n_cmp++;
    if ({dbg_state, moving_state, lamps()} !== {ST_COOL, 4'b0000, 4'b0000}) begin
      n_err++;
      $display("FAIL right_cool_first: got st=%0d mv=%b lamps=%b, want st=3 mv=0000 lamps=0", dbg_state, moving_state, lamps());
    end
    repeat (7) step();
    n_cmp++;
    if ({dbg_state, done} !== {ST_COOL, 1'b0}) begin
      n_err++;
      $display("FAIL right_cool_last: got st=%0d done=%b, want st=3 done=0", dbg_state, done);
    end
    step();
    n_cmp++;
    if ({dbg_state, done} !== {ST_IDLE, 1'b1}) begin
      n_err++;
      $display("FAIL right_done: got st=%0d done=%b, want st=0 done=1", dbg_state, done);
    end
    step();
  endtask

  task automatic test_power_drop();
    bit seen_done;
    offer(MV_TURN_LEFT);
    repeat (4) step();
    n_cmp++;
    if ({dbg_state, dut.u_timer.r_presc, dut.u_timer.r_count} !== {ST_TURN, 2'd3, 11'd1}) begin
      n_err++;
      $display("FAIL turn_cycle5: got st=%0d presc=%0d count=%0d, want st=2 presc=3 count=1",
               dbg_state, dut.u_timer.r_presc, dut.u_timer.r_count);
    end
    power = 1'b0;
    step();
    n_cmp++;
    if ({dbg_state, moving_state, busy, cmd_ready, done, lamps(), dut.u_timer.r_presc, dut.u_timer.r_count} !==
        {ST_IDLE, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 11'd0}) begin
      n_err++;
      $display("FAIL power_drop: got st=%0d mv=%b busy=%b rdy=%b done=%b lamps=%b presc=%0d count=%0d, want idle and all 0",
               dbg_state, moving_state, busy, cmd_ready, done, lamps(), dut.u_timer.r_presc, dut.u_timer.r_count);
    end
    power = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL power_restore_ready: got rdy=%b, want 1", cmd_ready);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (done !== 1'b0 || dbg_state !== ST_IDLE) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done) begin
      n_err++;
      $display("FAIL power_no_done: got done or state change after abort, want idle and done=0");
    end
  endtask

  task automatic test_illegal();
    offer(MV_BACKWARD);
    n_cmp++;
    if ({dbg_state, moving_state, lamps()} !== {ST_RUN, 4'b0010, 4'b0010}) begin
      n_err++;
      $display("FAIL backward_run: got st=%0d mv=%b lamps=%b, want st=1 mv=0010 lamps=0010", dbg_state, moving_state, lamps());
    end
    offer(4'b0110);
    n_cmp++;
    if ({dbg_state, moving_state, cmd_err, lamps()} !== {ST_IDLE, 4'b0000, 1'b1, 4'b0000}) begin
      n_err++;
      $display("FAIL illegal_0110: got st=%0d mv=%b err=%b lamps=%b, want st=0 mv=0000 err=1 lamps=0",
               dbg_state, moving_state, cmd_err, lamps());
    end
    step();
    n_cmp++;
    if (cmd_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_one_cycle: got err=%b, want 0", cmd_err);
    end
    offer(4'b1100);
    n_cmp++;
    if ({dbg_state, cmd_err} !== {ST_IDLE, 1'b1}) begin
      n_err++;
      $display("FAIL illegal_1100: got st=%0d err=%b, want st=0 err=1", dbg_state, cmd_err);
    end
    step();
  endtask

  task automatic test_back_to_back();
    offer(MV_FORWARD);
    cmd = MV_BACKWARD;
    cmd_valid = 1'b1;
    step();
    cmd = MV_STOP;
    n_cmp++;
    if ({dbg_state, moving_state, lamps(), cmd_ready} !== {ST_RUN, 4'b0010, 4'b0010, 1'b1}) begin
      n_err++;
      $display("FAIL run_switch: got st=%0d mv=%b lamps=%b rdy=%b, want st=1 mv=0010 lamps=0010 rdy=1",
               dbg_state, moving_state, lamps(), cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
    n_cmp++;
    if ({dbg_state, moving_state, lamps(), cmd_ready, cmd_err} !== {ST_IDLE, 4'b0000, 4'b0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL stop: got st=%0d mv=%b lamps=%b rdy=%b err=%b, want st=0 mv=0000 lamps=0 rdy=1 err=0",
               dbg_state, moving_state, lamps(), cmd_ready, cmd_err);
    end
  endtask

  task automatic test_reset_in_cool();
    bit seen_done;
    offer(MV_TURN_RIGHT);
    repeat (14) step();
    n_cmp++;
    if (dbg_state !== ST_COOL) begin
      n_err++;
      $display("FAIL pre_reset_cool: got st=%0d, want st=3", dbg_state);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if ({dbg_state, moving_state, busy, cmd_ready, done, cmd_err, lamps(), dut.u_timer.r_presc, dut.u_timer.r_count} !==
        {ST_IDLE, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 11'd0}) begin
      n_err++;
      $display("FAIL reset_in_cool: got st=%0d mv=%b busy=%b rdy=%b done=%b err=%b lamps=%b presc=%0d count=%0d, want idle and all 0",
               dbg_state, moving_state, busy, cmd_ready, done, cmd_err, lamps(), dut.u_timer.r_presc, dut.u_timer.r_count);
    end
    rst = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done !== 1'b0) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done) begin
      n_err++;
      $display("FAIL reset_no_done: got done=1 after abort, want 0");
    end
  endtask

  initial begin
    rst = 1'b0; power = 1'b1; cmd_valid = 1'b0; cmd = 4'b0000;
    test_reset_forward();
    test_turn_left();
    test_ignore_in_cool();
    test_power_drop();
    test_illegal();
    test_back_to_back();
    test_reset_in_cool();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/move_executor.md
MOVE_EXECUTOR -- requirements
Module: move_executor

Interface
REQ-001 The block SHALL have parameter CLK_PER_MS, default 100000, meaning sys_clk cycles per millisecond tick.
REQ-002 The block SHALL have parameter TURN_MS, default 900, meaning turn duration in ms (1..2047).
REQ-003 The block SHALL have parameter COOL_MS, default 500, meaning post-turn cooldown in ms (1..2047).
REQ-004 The block SHALL have port sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port power  input  1  1 = car powered; 0 forces idle.
REQ-007 The block SHALL have port cmd_valid  input  1  a moving command is offered.
REQ-008 The block SHALL have port cmd  input  4  moving command: 0000 STOP, 0001 FORWARD, 0010 BACKWARD, 0100 TURN_LEFT, 1000 TURN_RIGHT.
REQ-009 The block SHALL have port cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-010 The block SHALL have port moving_state  output  4  command currently applied to the motors, same encoding as cmd.
REQ-011 The block SHALL have port busy  output  1  high in TURN or COOL.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse when a turn and its cooldown complete.
REQ-013 The block SHALL have port cmd_err  output  1  one-cycle pulse when an accepted cmd is not a legal encoding.
REQ-014 The block SHALL have ports move_forward_light, move_backward_light, turn_left_light, turn_right_light  output  1 each  lamps.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, TURN, COOL; cmd_ready = power and state in {IDLE, RUN}, combinational.
REQ-016 On acceptance, STOP SHALL go to IDLE; FORWARD or BACKWARD SHALL go to RUN and latch moving_state; TURN_LEFT or TURN_RIGHT SHALL go to TURN and latch moving_state.
REQ-017 On acceptance of an illegal cmd, the block SHALL go to IDLE, set moving_state 0000, and pulse cmd_err.
REQ-018 In IDLE, moving_state SHALL be 0000; in RUN, it SHALL hold the latched command until a new command is accepted.
REQ-019 On entry to TURN or COOL, the ms prescaler (0..CLK_PER_MS-1) and the 11-bit duration counter SHALL both be reloaded.
REQ-020 TURN SHALL last exactly TURN_MS*CLK_PER_MS cycles, then go to COOL with moving_state 0000.
REQ-021 COOL SHALL last exactly COOL_MS*CLK_PER_MS cycles, then go to IDLE; done SHALL be high in the first IDLE cycle.
REQ-022 In TURN and COOL, cmd_valid SHALL be ignored (cmd_ready=0); commands are not queued.
REQ-023 When power=0 in any state, the block SHALL go to IDLE next cycle, with moving_state 0000, counters cleared, and no done pulse; this has priority over command acceptance and timer expiry.
REQ-024 Lamps SHALL be registered decodes of moving_state: forward=0001, backward=0010, left=0100, right=1000; all lamps SHALL be 0 otherwise.
REQ-025 If timer expiry and cmd_valid fall in the same cycle, expiry SHALL win; the command SHALL be acceptable from the next cycle.

Reset
REQ-026 While rst=0 at a clock edge, the block SHALL be in state IDLE, with moving_state=0000, cmd_ready=0 in the following cycle until rst=1, busy=0, done=0, cmd_err=0, all lamps 0, and prescaler and counter at 0.
REQ-027 A reset during TURN or COOL SHALL abort the turn without a done pulse.

Structure
REQ-028 The moving-state encodings (STOP, FORWARD, BACKWARD, TURN_LEFT, TURN_RIGHT) and FSM state codes SHALL live in a shared package/include, used by this block and the semiauto mode controller.
REQ-029 One sub-module, ms_timer (prescaler plus down-counter with load and expire outputs), SHALL be instantiated once and reused for TURN and COOL.

Verification (CLK_PER_MS=4, TURN_MS=3, COOL_MS=2)
REQ-030 Reset then FORWARD: rst=0 for 2 cycles, then cmd=0001 valid for 1 cycle -> next cycle moving_state=0001, move_forward_light=1, cmd_ready stays 1.
REQ-031 TURN_LEFT from RUN -> TURN for 12 cycles (moving_state 0100, busy=1), COOL for 8 cycles (0000), then done=1 for exactly 1 cycle, with cmd_ready=0 throughout TURN and COOL.
REQ-032 cmd=1000 offered during COOL -> ignored; TURN_RIGHT is accepted only after done, with its own full 12+8 cycle sequence.
REQ-033 power dropped in TURN cycle 5 -> next cycle IDLE, moving_state 0000, no done; power restored -> cmd_ready=1.
REQ-034 cmd=0110 accepted in RUN -> cmd_err pulse for 1 cycle, state IDLE, all lamps 0.
REQ-035 rst=0 asserted in COOL -> IDLE next edge, no done pulse, counters 0.
